// File: rtl/ir_pkg.sv
// Shared constants and timing helpers for the multi-channel IR sense block.
package ir_pkg;

    localparam int PERIOD_DEF      = 500000;
    localparam int ON_TIME_DEF     = 25000;
    localparam int PERIOD_FAST_DEF = 64;
    localparam int ON_FAST_DEF     = 8;
    localparam int DEBOUNCE_W      = 4;

    // Strobe period actually used, picked by the fast-simulation switch.
    function automatic int eff_period(input int fast_sim, input int period,
                                      input int period_fast);
        return (fast_sim != 0) ? period_fast : period;
    endfunction

    // Emitter on-time actually used, picked by the fast-simulation switch.
    function automatic int eff_on(input int fast_sim, input int on_time,
                                  input int on_fast);
        return (fast_sim != 0) ? on_fast : on_time;
    endfunction

endpackage

// File: rtl/ir_chan.sv
// One IR channel: 2-flop synchronizer, inversion to active-high,
// sample-qualified debounce, level register and 1-cycle edge pulses.
module ir_chan
    import ir_pkg::*;
#(
    parameter int DEBOUNCE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic smpl,
    input  logic ch_en,
    input  logic ir_n,
    output logic ir,
    output logic ir_rise,
    output logic ir_fall
);

    localparam logic [DEBOUNCE_W-1:0] DB_LAST = DEBOUNCE_W'(DEBOUNCE - 1);

    logic                  sync1;
    logic                  sync2;
    logic                  sample;
    logic [DEBOUNCE_W-1:0] dcnt;
    logic                  toggled;

    assign sample = ~sync2;

    // Bring the asynchronous pin into clk; idle level is "no reflection".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= ir_n;
            sync2 <= sync1;
        end
    end

    // Debounce at the sample point; masking wins and silently drops the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= 1'b0;
            dcnt    <= '0;
            toggled <= 1'b0;
        end else begin
            toggled <= 1'b0;
            if (!ch_en) begin
                ir   <= 1'b0;
                dcnt <= '0;
            end else if (smpl) begin
                if (sample != ir) begin
                    if (dcnt == DB_LAST) begin
                        ir      <= sample;
                        dcnt    <= '0;
                        toggled <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end else begin
                    dcnt <= '0;
                end
            end
        end
    end

    // Edge pulses one cycle after the level change, lined up with smpl_vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_rise <= 1'b0;
            ir_fall <= 1'b0;
        end else begin
            ir_rise <= toggled & ir & ch_en;
            ir_fall <= toggled & ~ir & ch_en;
        end
    end

endmodule

// File: rtl/ir_sense_multi.sv
// Shared IR emitter strobe with NUM_CH sampled, debounced sensor channels.
// The period counter drives IR_en and a single sample point at the last
// cycle of the on-window; each channel debounces independently.
module ir_sense_multi
    import ir_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int FAST_SIM    = 1,
    parameter int PERIOD      = PERIOD_DEF,
    parameter int ON_TIME     = ON_TIME_DEF,
    parameter int PERIOD_FAST = PERIOD_FAST_DEF,
    parameter int ON_FAST     = ON_FAST_DEF,
    parameter int DEBOUNCE    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cont,
    input  logic [NUM_CH-1:0] ir_n,
    output logic              IR_en,
    output logic [NUM_CH-1:0] ir,
    output logic [NUM_CH-1:0] ir_rise,
    output logic [NUM_CH-1:0] ir_fall,
    output logic              smpl_vld
);

    localparam int P  = eff_period(FAST_SIM, PERIOD, PERIOD_FAST);
    localparam int ON = eff_on(FAST_SIM, ON_TIME, ON_FAST);
    localparam int CW = (P > 1) ? $clog2(P) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
    localparam logic [CW-1:0] CNT_ON   = CW'(ON);
    localparam logic [CW-1:0] CNT_SMPL = CW'(ON - 1);

    if ((ON < 4) || (ON >= P)) begin : g_bad_on
        $error("ir_sense_multi: on-time must satisfy 4 <= ON < P");
    end
    if ((DEBOUNCE < 1) || (DEBOUNCE > 15)) begin : g_bad_db
        $error("ir_sense_multi: DEBOUNCE must be in 1..15");
    end
    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_ch
        $error("ir_sense_multi: NUM_CH must be in 1..16");
    end

    logic [CW-1:0] cnt;
    logic          smpl;
    logic          smpl_d;

    assign smpl = (cnt == CNT_SMPL);

    // Free-running period counter; wraps to 0 after P-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Emitter window: on at cnt==0, off at cnt==ON; cont holds it on and the
    // window only takes over again at the next cnt==ON edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IR_en <= 1'b0;
        end else if (cont) begin
            IR_en <= 1'b1;
        end else if (cnt == '0) begin
            IR_en <= 1'b1;
        end else if (cnt == CNT_ON) begin
            IR_en <= 1'b0;
        end
    end

    // Sample-valid trails the sample edge by one cycle so it coincides with
    // the channels' edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpl_d   <= 1'b0;
            smpl_vld <= 1'b0;
        end else begin
            smpl_d   <= smpl;
            smpl_vld <= smpl_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ir_chan #(
            .DEBOUNCE (DEBOUNCE)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .smpl    (smpl),
            .ch_en   (ch_en[i]),
            .ir_n    (ir_n[i]),
            .ir      (ir[i]),
            .ir_rise (ir_rise[i]),
            .ir_fall (ir_fall[i])
        );
    end

endmodule
